// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle shift controller for the ALU shift path. Accepts
//               one request at a time over a start/done handshake and applies
//               SLL/SRL/SRA/ROR one slice per clock until the amount is spent.
//               Optional macro SHIFT_FAST_EN: up to 4 positions per SHIFT cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int W   = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [W-1:0]   a,
    input  logic [SHW-1:0] shamt,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   result
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [1:0] c_OP_SLL = 2'b00;
    localparam logic [1:0] c_OP_SRL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b10;

    // Maximum positions consumed per SHIFT cycle.
`ifdef SHIFT_FAST_EN
    localparam int c_STEP_MAX = 4;
`else
    localparam int c_STEP_MAX = 1;
`endif
    localparam logic [SHW-1:0] c_STEP_MAX_V = SHW'(c_STEP_MAX);

    logic [1:0]     r_state;
    logic [1:0]     r_op;
    logic [W-1:0]   r_work;
    logic [SHW-1:0] r_cnt;
    logic           r_busy;
    logic           r_done;
    logic [W-1:0]   r_result;

    logic [SHW-1:0] w_step;
    logic [W-1:0]   w_next;

    // One-position shift slice; the multi-step path is a chain of these so
    // both builds produce bit-identical results.
    function automatic logic [W-1:0] shift1(input logic [1:0] f_op,
                                            input logic [W-1:0] f_v);
        case (f_op)
            c_OP_SLL: shift1 = {f_v[W-2:0], 1'b0};
            c_OP_SRL: shift1 = {1'b0, f_v[W-1:1]};
            c_OP_SRA: shift1 = {f_v[W-1], f_v[W-1:1]};
            default:  shift1 = {f_v[0], f_v[W-1:1]};
        endcase
    endfunction

    // Step size min(cnt, c_STEP_MAX) and the working value after that many slices.
    always_comb begin
        w_step = (r_cnt > c_STEP_MAX_V) ? c_STEP_MAX_V : r_cnt;
        w_next = r_work;
        for (int i = 0; i < c_STEP_MAX; i++) begin
            if (SHW'(i) < w_step) begin
                w_next = shift1(r_op, w_next);
            end
        end
    end

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_op     <= 2'b00;
            r_work   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_work  <= a;
                        r_op    <= op;
                        r_cnt   <= shamt;
                        r_busy  <= 1'b1;
                        r_state <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_done   <= 1'b1;
                        r_result <= r_work;
                        r_state  <= c_DONE;
                    end else begin
                        r_work <= w_next;
                        r_cnt  <= r_cnt - w_step;
                    end
                end
                c_DONE: begin
                    // start seen here is deliberately dropped; acceptance is IDLE-only.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Directed self-checking bench for shift_sequencer. Expected
//               results and latencies are queued when a request is driven and
//               popped when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int W   = 32;
    localparam int SHW = 5;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [SHW-1:0] shamt;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_res_q[$];
    int           exp_lat_q[$];

    shift_sequencer #(.W(W), .SHW(SHW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    function automatic int exp_latency(input int sh);
`ifdef SHIFT_FAST_EN
        return (sh + 3) / 4 + 1;
`else
        return sh + 1;
`endif
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request so the next rising edge accepts it, then scramble the
    // inputs to show they no longer matter.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] av,
                         input logic [SHW-1:0] sh, input logic [W-1:0] exp_res);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        shamt = sh;
        exp_res_q.push_back(exp_res);
        exp_lat_q.push_back(exp_latency(int'(sh)));
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        shamt = SHW'($urandom);
        check("busy_after_accept", W'(busy), W'(1));
    endtask

    // Wait (bounded) for done, then compare latency and result against the scoreboard.
    task automatic wait_done(input string tag);
        int cyc;
        logic [W-1:0] er;
        int el;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 100);
        er = exp_res_q.pop_front();
        el = exp_lat_q.pop_front();
        check({tag, "_done_seen"}, W'(done), W'(1));
        check({tag, "_latency"}, W'(cyc), W'(el));
        check({tag, "_result"}, result, er);
        check({tag, "_busy_in_done"}, W'(busy), W'(1));
        @(posedge clk);
        #1;
        check({tag, "_done_1cyc"}, W'(done), W'(0));
        check({tag, "_busy_drop"}, W'(busy), W'(0));
        check({tag, "_result_hold"}, result, er);
    endtask

    task automatic run_req(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                           input logic [SHW-1:0] sh, input logic [W-1:0] exp_res);
        issue(o, av, sh, exp_res);
        wait_done(tag);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        shamt = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", W'(busy), W'(0));

        // Main function and boundary amounts
        run_req("srl31",   2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
        run_req("sra4",    2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000);
        run_req("sll0",    2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678);
        run_req("ror1",    2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000);
        run_req("ror8",    2'b11, 32'hDEAD_BEEF, 5'd8,  32'hEFDE_ADBE);
        run_req("sll4",    2'b00, 32'h1234_5678, 5'd4,  32'h2345_6780);
        run_req("srl28",   2'b01, 32'hF000_0000, 5'd28, 32'h0000_000F);
        run_req("sra7pos", 2'b10, 32'h7000_0000, 5'd7,  32'h00E0_0000);
        run_req("ror0",    2'b11, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D);
        run_req("sra31",   2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);

        // start pulsed during SHIFT is ignored; start in DONE is ignored too
        issue(2'b00, 32'h0000_0001, 5'd10, 32'h0000_0400);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'hFFFF_FFFF;
        shamt = 5'd3;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    check("ign_result", result, exp_res_q.pop_front());
                    void'(exp_lat_q.pop_front());
                    start = 1'b1;
                    a     = 32'h5555_5555;
                    shamt = 5'd2;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    check("ign_done_start_busy", W'(busy), W'(0));
                end
            end
        end
        check("ign_one_pulse", W'(pulses), W'(1));
        check("ign_still_idle", W'(busy), W'(0));

        // Asynchronous reset mid-operation abandons the request
        issue(2'b01, 32'h8000_0000, 5'd20, 32'h0000_0800);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", W'(busy), W'(0));
        check("arst_done", W'(done), W'(0));
        check("arst_result", result, '0);
        exp_res_q.delete();
        exp_lat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("arst_no_done", W'(pulses), W'(0));
        run_req("post_rst_sll1", 2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002);

        check("sb_empty", W'(exp_res_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
